// File: rtl/display_pkg.sv
// Shared definitions for the multiplexed display scanner: FSM states and default timing.
package display_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    BLANK = 2'd1,
    SHOW  = 2'd2
  } scan_state_t;

  localparam int DEF_NUM_DIGITS   = 4;
  localparam int DEF_SLOT_CYCLES  = 50000;
  localparam int DEF_BLANK_CYCLES = 500;

endpackage

// File: rtl/display_scanner.sv
// Time-multiplexed digit scanner: per-slot blanking, anode select, and frame-synchronous
// transfer of newly loaded digit codes into the displayed set.
module display_scanner
  import display_pkg::*;
#(
  parameter int NUM_DIGITS   = DEF_NUM_DIGITS,
  parameter int SLOT_CYCLES  = DEF_SLOT_CYCLES,
  parameter int BLANK_CYCLES = DEF_BLANK_CYCLES
) (
  input  logic                    clock,
  input  logic                    resetn,
  input  logic                    enable,
  input  logic                    load,
  input  logic [2*NUM_DIGITS-1:0] digits_in,
  output logic [1:0]              number,
  output logic [NUM_DIGITS-1:0]   an,
  output logic                    blank,
  output logic                    frame_done,
  output logic                    load_ack
);

  localparam int CW = $clog2(SLOT_CYCLES);
  localparam int IW = $clog2(NUM_DIGITS);
  localparam int DW = 2 * NUM_DIGITS;
  localparam logic [CW-1:0] CNT_LAST  = CW'(SLOT_CYCLES - 1);
  localparam logic [CW-1:0] CNT_BLANK = CW'(BLANK_CYCLES);
  localparam logic [IW-1:0] IDX_LAST  = IW'(NUM_DIGITS - 1);

  scan_state_t           state, state_n;
  logic [CW-1:0]         cnt, cnt_n;
  logic [IW-1:0]         idx, idx_n;
  logic [DW-1:0]         active, active_n;
  logic [DW-1:0]         shadow, shadow_n;
  logic                  pending, pending_n;
  logic                  boundary;
  logic [NUM_DIGITS-1:0] an_n;
  logic [1:0]            number_n;
  logic                  blank_n;
  logic                  ack_n;

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      state      <= IDLE;
      cnt        <= '0;
      idx        <= '0;
      active     <= '0;
      shadow     <= '0;
      pending    <= 1'b0;
      an         <= '1;
      number     <= 2'b00;
      blank      <= 1'b1;
      frame_done <= 1'b0;
      load_ack   <= 1'b0;
    end else begin
      state      <= state_n;
      cnt        <= cnt_n;
      idx        <= idx_n;
      active     <= active_n;
      shadow     <= shadow_n;
      pending    <= pending_n;
      an         <= an_n;
      number     <= number_n;
      blank      <= blank_n;
      frame_done <= boundary;
      load_ack   <= ack_n;
    end
  end

  always_comb begin
    state_n  = IDLE;
    cnt_n    = '0;
    idx_n    = '0;
    boundary = 1'b0;
    // Leaving IDLE is treated as a frame start so pending codes show immediately.
    if (enable) begin
      if (state == IDLE) begin
        boundary = 1'b1;
      end else if (cnt == CNT_LAST) begin
        boundary = (idx == IDX_LAST);
        idx_n    = (idx == IDX_LAST) ? '0 : idx + 1'b1;
      end else begin
        cnt_n = cnt + 1'b1;
        idx_n = idx;
      end
      state_n = (cnt_n < CNT_BLANK) ? BLANK : SHOW;
    end

    shadow_n  = load ? digits_in : shadow;
    pending_n = pending | load;
    active_n  = active;
    ack_n     = 1'b0;
    // A load on the boundary edge bypasses the shadow and wins over an older pending value.
    if (boundary) begin
      pending_n = 1'b0;
      ack_n     = load | pending;
      if (load)         active_n = digits_in;
      else if (pending) active_n = shadow;
    end

    an_n     = '1;
    number_n = 2'b00;
    for (int k = 0; k < NUM_DIGITS; k++) begin
      if (idx_n == IW'(k)) begin
        number_n = active_n[2*k +: 2];
        if (state_n == SHOW) an_n[k] = 1'b0;
      end
    end
    blank_n = (state_n != SHOW);
  end

endmodule

// File: tb/tb_display_scanner.sv
// Directed bench for display_scanner with 4 digits, 8-cycle slots and 2 blanking cycles.
module tb_display_scanner;

  localparam int ND = 4;
  localparam int SC = 8;
  localparam int BC = 2;

  logic       clock = 1'b0;
  logic       resetn = 1'b0;
  logic       enable = 1'b0;
  logic       load = 1'b0;
  logic [7:0] digits_in = 8'h00;
  logic [1:0] number;
  logic [3:0] an;
  logic       blank;
  logic       frame_done;
  logic       load_ack;

  int total = 0;
  int bad = 0;
  int c = 0;
  int acks = 0;

  display_scanner #(
    .NUM_DIGITS  (ND),
    .SLOT_CYCLES (SC),
    .BLANK_CYCLES(BC)
  ) dut (
    .clock     (clock),
    .resetn    (resetn),
    .enable    (enable),
    .load      (load),
    .digits_in (digits_in),
    .number    (number),
    .an        (an),
    .blank     (blank),
    .frame_done(frame_done),
    .load_ack  (load_ack)
  );

  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, c);
    end
  endtask

  task automatic tick();
    @(negedge clock);
    c++;
    if (load_ack) acks++;
  endtask

  task automatic go_to(input int target);
    while (c < target) tick();
  endtask

  initial begin
    logic [3:0] exp_an;

    // Reset values
    #12;
    check("rst_an", an, 4'hF);
    check("rst_blank", blank, 1);
    check("rst_number", number, 0);
    check("rst_frame_done", frame_done, 0);
    check("rst_load_ack", load_ack, 0);
    @(negedge clock);
    resetn = 1'b1;
    tick();
    check("idle_an", an, 4'hF);
    check("idle_blank", blank, 1);

    // Free-running scan, two frames
    enable = 1'b1;
    c = -1;
    for (int i = 0; i < 64; i++) begin
      tick();
      exp_an = 4'hF;
      if (c % SC >= BC) exp_an[(c / SC) % ND] = 1'b0;
      check("scan_an", an, exp_an);
      check("scan_blank", blank, (c % SC) < BC);
      check("scan_frame_done", frame_done, (c % 32) == 0);
      check("scan_load_ack", load_ack, 0);
    end

    // Mid-frame load, transferred at next wrap
    go_to(70);
    load = 1'b1;
    digits_in = 8'b10_01_00_10;
    tick();
    load = 1'b0;
    check("mid_no_ack", load_ack, 0);
    go_to(96);
    check("wrap_frame_done", frame_done, 1);
    check("wrap_load_ack", load_ack, 1);
    check("num_idx0", number, 2);
    tick();
    check("ack_single_cycle", load_ack, 0);
    go_to(104);
    check("num_idx1", number, 0);
    go_to(112);
    check("num_idx2", number, 1);
    go_to(120);
    check("num_idx3", number, 2);

    // Two loads in one frame: last wins, one ack
    go_to(122);
    load = 1'b1;
    digits_in = 8'h00;
    tick();
    load = 1'b0;
    go_to(124);
    load = 1'b1;
    digits_in = 8'hAA;
    tick();
    load = 1'b0;
    acks = 0;
    go_to(128);
    check("two_fd", frame_done, 1);
    check("two_ack", load_ack, 1);
    check("two_num0", number, 2);
    go_to(136);
    check("two_num1", number, 2);
    go_to(159);
    check("two_ack_count", acks, 1);

    // Load coincident with the wrap edge bypasses the shadow
    load = 1'b1;
    digits_in = 8'h55;
    tick();
    load = 1'b0;
    check("bypass_ack", load_ack, 1);
    check("bypass_fd", frame_done, 1);
    check("bypass_num0", number, 1);
    go_to(168);
    check("bypass_num1", number, 1);

    // Enable dropped during SHOW of idx 2, load while idle, re-enable
    go_to(180);
    check("show_idx2_an", an, 4'b1011);
    check("show_idx2_blank", blank, 0);
    enable = 1'b0;
    tick();
    check("dis_an", an, 4'hF);
    check("dis_blank", blank, 1);
    check("dis_fd", frame_done, 0);
    load = 1'b1;
    digits_in = 8'hE4;
    tick();
    load = 1'b0;
    tick();
    check("idle_load_no_ack", load_ack, 0);
    enable = 1'b1;
    c = -1;
    tick();
    check("reen_fd", frame_done, 1);
    check("reen_ack", load_ack, 1);
    check("reen_an", an, 4'hF);
    check("reen_blank", blank, 1);
    check("reen_num0", number, 0);
    go_to(2);
    check("reen_an_idx0", an, 4'b1110);
    go_to(10);
    check("reen_an_idx1", an, 4'b1101);
    check("reen_num1", number, 1);
    go_to(24);
    check("reen_num3", number, 3);

    // Asynchronous reset mid-slot
    go_to(28);
    #2;
    resetn = 1'b0;
    #1;
    check("arst_an", an, 4'hF);
    check("arst_blank", blank, 1);
    check("arst_number", number, 0);
    check("arst_fd", frame_done, 0);
    check("arst_ack", load_ack, 0);
    @(negedge clock);
    resetn = 1'b1;
    c = -1;
    tick();
    check("post_rst_fd", frame_done, 1);
    check("post_rst_ack", load_ack, 0);
    check("post_rst_blank", blank, 1);
    go_to(2);
    check("post_rst_an_idx0", an, 4'b1110);
    go_to(24);
    check("post_rst_num3", number, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
